key_debounce_encoder: RTL and testbench

KEY_DEBOUNCE_ENCODER -- requirements
Module: key_debounce_encoder

---
 rtl/piano_pkg.sv | 28 ++
 rtl/debounce_bit.sv | 57 +++++
 rtl/key_debounce_encoder.sv | 87 ++++++++
 tb/tb_key_debounce_encoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the piano front end and the piano core.
//   NUM_KEYS       : number of note switches on the keyboard
//   note_t         : 3-bit note code, NOTE_C4 (lowest pitch) .. NOTE_C5
//   index_to_note  : maps a switch index (sw[7]=C4 .. sw[0]=C5) to its code
// -----------------------------------------------------------------------------
package piano_pkg;

    localparam int NUM_KEYS = 8;

    typedef enum logic [2:0] {
        NOTE_C4 = 3'd0,
        NOTE_D  = 3'd1,
        NOTE_E  = 3'd2,
        NOTE_F  = 3'd3,
        NOTE_G  = 3'd4,
        NOTE_A  = 3'd5,
        NOTE_B  = 3'd6,
        NOTE_C5 = 3'd7
    } note_t;

    // Switch index runs opposite to pitch: the highest index is C4.
    function automatic note_t index_to_note(input int idx);
        return note_t'(NUM_KEYS - 1 - idx);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Synchronises one raw switch into the CLK domain and accepts a level change
// only after DB_CYCLES consecutive synchronised samples disagree with the
// current clean level.
//   CLK     : system clock, rising edge
//   RESET_N : asynchronous active-low reset
//   raw     : asynchronous switch input
//   clean   : debounced level
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic raw,
    output logic clean
);

    localparam int                CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DB_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic [CNT_W-1:0] cnt;

    // NOTE: the synchroniser flops are reset too, so a stale pre-reset sample
    // can never be mistaken for a switch change after reset is released.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (sync_out == clean) begin
            // Any agreeing sample restarts the stability window.
            cnt <= '0;
        end else if (cnt == LAST) begin
            // DB_CYCLES consecutive disagreeing samples: accept the new level.
            clean <= ~clean;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_debounce_encoder.sv
// -----------------------------------------------------------------------------
// key_debounce_encoder
// Debounces the note switches and encodes the lowest-pitch active key into a
// note code with press/release strobes for the piano core.
//   CLK           : system clock, rising edge
//   RESET_N       : asynchronous active-low reset
//   sw            : raw note switches, sw[7]=C4 .. sw[0]=C5
//   sw_clean      : debounced switch levels, bit-aligned with sw
//   key_code      : code of the lowest-pitch on switch; holds when none is on
//   key_valid     : at least one debounced switch is on
//   press_pulse   : one-cycle strobe on a new note
//   release_pulse : one-cycle strobe when the last key goes off
//   multi_key     : more than one debounced switch is on
// -----------------------------------------------------------------------------
import piano_pkg::*;

module key_debounce_encoder #(
    parameter int DB_CYCLES = 1000000,
    parameter int NUM_KEYS  = piano_pkg::NUM_KEYS
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] sw,
    output logic [NUM_KEYS-1:0] sw_clean,
    output logic [2:0]          key_code,
    output logic                key_valid,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic                multi_key
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .CLK    (CLK),
            .RESET_N(RESET_N),
            .raw    (sw[g]),
            .clean  (sw_clean[g])
        );
    end

    note_t code_q;
    note_t next_code;
    logic  next_valid;
    logic  next_multi;
    int    on_count;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_code = code_q;
        on_count  = 0;
        // Ascending scan: the last set bit seen is the highest index, which is
        // the lowest pitch, so it wins. Multiple keys qualifying on one edge
        // therefore resolve to a single code.
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (sw_clean[i]) begin
                next_code = index_to_note(i);
                on_count  = on_count + 1;
            end
        end
        next_valid = (on_count != 0);
        next_multi = (on_count > 1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            code_q        <= NOTE_C4;
            key_valid     <= 1'b0;
            multi_key     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            code_q        <= next_code;
            key_valid     <= next_valid;
            multi_key     <= next_multi;
            // A new note is either a first key or a change of the selected key
            // while something stays held (e.g. releasing the lower-pitch key).
            press_pulse   <= next_valid && (!key_valid || (next_code != code_q));
            release_pulse <= !next_valid && key_valid;
        end
    end

    assign key_code = code_q;

endmodule

// File: tb/tb_key_debounce_encoder.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_key_debounce_encoder
// Directed bench for key_debounce_encoder with DB_CYCLES=8 and a 2 ns clock.
// Edge index 0 of a watch window is the first rising edge after the stimulus
// change; sw_clean follows at edge 9 and the registered outputs at edge 10.
// -----------------------------------------------------------------------------
module tb_key_debounce_encoder;

    localparam int DB = 8;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] sw;
    logic [7:0] sw_clean;
    logic [2:0] key_code;
    logic       key_valid;
    logic       press_pulse;
    logic       release_pulse;
    logic       multi_key;

    int tests = 0;
    int fails = 0;

    // Window statistics gathered by watch().
    int w_press;
    int w_rel;
    int w_both;
    int w_first_press;
    int w_first_rel;
    int w_first_clean;
    int w_any_valid;
    int w_any_multi;
    int codes[$];

    key_debounce_encoder #(
        .DB_CYCLES(DB),
        .NUM_KEYS (8)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .sw           (sw),
        .sw_clean     (sw_clean),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .multi_key    (multi_key)
    );

    always #1 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observe n rising edges, sampling on each following falling edge.
    task automatic watch(input int n);
        w_press = 0; w_rel = 0; w_both = 0;
        w_first_press = -1; w_first_rel = -1; w_first_clean = -1;
        w_any_valid = 0; w_any_multi = 0;
        codes.delete();
        for (int e = 0; e < n; e++) begin
            @(negedge CLK);
            if (press_pulse) begin
                w_press++;
                if (w_first_press < 0) w_first_press = e;
                codes.push_back(int'(key_code));
            end
            if (release_pulse) begin
                w_rel++;
                if (w_first_rel < 0) w_first_rel = e;
            end
            if (press_pulse && release_pulse) w_both++;
            if (sw_clean != 8'h00 && w_first_clean < 0) w_first_clean = e;
            if (key_valid) w_any_valid = 1;
            if (multi_key) w_any_multi = 1;
        end
    endtask

    function automatic int code0();
        return (codes.size() > 0) ? codes[0] : -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_sw_clean"}, 32'(sw_clean), 0);
        check({tag, "_key_code"}, 32'(key_code), 0);
        check({tag, "_key_valid"}, 32'(key_valid), 0);
        check({tag, "_press"}, 32'(press_pulse), 0);
        check({tag, "_release"}, 32'(release_pulse), 0);
        check({tag, "_multi"}, 32'(multi_key), 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        RESET_N = 1'b0;
        sw      = 8'h00;
        #5;
        check_all_zero("reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        watch(4);

        // ---------------- short glitch on sw[3] is rejected ----------------
        sw[3] = 1'b1;
        watch(5);
        sw[3] = 1'b0;
        watch(16);
        check("glitch_press", 32'(w_press), 0);
        check("glitch_clean", 32'(w_first_clean), 32'hFFFF_FFFF);
        check("glitch_valid", 32'(w_any_valid), 0);

        // ---------------- bouncing sw[5], then held high ----------------
        fork
            begin
                #0.5;
                for (int k = 0; k < 8; k++) begin
                    sw[5] = (k % 2 == 0);
                    #1;
                end
                sw[5] = 1'b1;
            end
            watch(16);
        join
        check("bounce_clean_edge", 32'(w_first_clean), 9);
        check("bounce_press_cnt", 32'(w_press), 1);
        check("bounce_press_edge", 32'(w_first_press), 10);
        check("bounce_code", 32'(code0()), 2);
        sw = 8'h00;
        watch(14);
        check("bounce_release_cnt", 32'(w_rel), 1);

        // ---------------- sw[7] held 25 cycles then released ----------------
        sw = 8'h80;
        watch(25);
        check("c4_press_cnt", 32'(w_press), 1);
        check("c4_press_edge", 32'(w_first_press), 10);
        check("c4_code", 32'(code0()), 0);
        check("c4_clean", 32'(sw_clean), 32'h80);
        check("c4_rel_early", 32'(w_rel), 0);
        sw = 8'h00;
        watch(15);
        check("c4_rel_cnt", 32'(w_rel), 1);
        check("c4_rel_edge", 32'(w_first_rel), 10);
        check("c4_rel_press", 32'(w_press), 0);
        check("c4_code_hold", 32'(key_code), 0);
        check("c4_valid_off", 32'(key_valid), 0);

        // ---------------- sw[4], add sw[7], drop sw[7], drop sw[4] ----------------
        sw = 8'h10;
        watch(12);
        check("f_press_edge", 32'(w_first_press), 10);
        check("f_code", 32'(code0()), 3);
        check("f_multi", 32'(w_any_multi), 0);
        sw = 8'h90;
        watch(12);
        check("fc4_press_cnt", 32'(w_press), 1);
        check("fc4_code", 32'(code0()), 0);
        check("fc4_multi", 32'(multi_key), 1);
        check("fc4_rel", 32'(w_rel), 0);
        sw = 8'h10;
        watch(12);
        check("fback_press_cnt", 32'(w_press), 1);
        check("fback_code", 32'(code0()), 3);
        check("fback_multi", 32'(multi_key), 0);
        check("fback_rel", 32'(w_rel), 0);
        check("fback_valid", 32'(key_valid), 1);
        sw = 8'h00;
        watch(12);
        check("foff_rel_cnt", 32'(w_rel), 1);
        check("foff_press", 32'(w_press), 0);
        check("foff_code_hold", 32'(key_code), 3);

        // ---------------- two keys qualifying on the same edge ----------------
        sw = 8'h24;
        watch(12);
        check("dual_press_cnt", 32'(w_press), 1);
        check("dual_code", 32'(code0()), 2);
        check("dual_multi", 32'(multi_key), 1);
        check("dual_clean", 32'(sw_clean), 32'h24);
        sw = 8'h00;
        watch(12);
        check("dual_rel_cnt", 32'(w_rel), 1);
        check("dual_overlap", 32'(w_both), 0);

        // ---------------- reset mid-count with sw[0] held ----------------
        sw = 8'h01;
        watch(7);                        // counter has reached 5
        check("midcnt_clean", 32'(sw_clean), 0);
        RESET_N = 1'b0;
        #0.2;
        check_all_zero("async_reset");
        @(negedge CLK);
        @(negedge CLK);
        check_all_zero("held_reset");
        RESET_N = 1'b1;
        watch(14);
        check("rst_press_cnt", 32'(w_press), 1);
        check("rst_press_edge", 32'(w_first_press), 10);
        check("rst_code", 32'(code0()), 7);
        check("rst_clean_edge", 32'(w_first_clean), 9);
        sw = 8'h00;
        watch(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
